// File: rtl/vdp_vram_arbiter.sv
// vdp_vram_arbiter: one access per ce_vdp slot on the VRAM port, shared by the renderer,
// a CPU write queue and a single CPU read, with a starvation guard for the CPU.
module vdp_vram_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_vdp,
   input  logic        ren_req,
   input  logic [13:0] ren_addr,
   output logic        ren_ack,
   output logic [7:0]  ren_data,
   output logic        ren_valid,
   input  logic        cpu_wr_req,
   input  logic [13:0] cpu_wr_addr,
   input  logic [7:0]  cpu_wr_data,
   output logic        cpu_wr_ready,
   input  logic        cpu_rd_req,
   input  logic [13:0] cpu_rd_addr,
   output logic        cpu_rd_busy,
   output logic [7:0]  cpu_rd_data,
   output logic        cpu_rd_valid,
   output logic [13:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [4:0]  fifo_level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
   typedef enum logic [1:0] {IDLE, REN, CPU_WR, CPU_RD} state_t;
   state_t state_q, state_d;
   logic [21:0] fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [4:0] level_q, level_d;
   logic [SW-1:0] starve_q, starve_d;
   logic rd_pend_q, rd_pend_d;
   logic [13:0] rd_addr_q, rd_addr_d, mem_addr_q;
   logic [7:0] mem_wdata_q, ren_data_q, ren_data_d, cpu_rd_data_q, cpu_rd_data_d;
   logic ren_valid_q, ren_valid_d, cpu_rd_valid_q, cpu_rd_valid_d;
   logic slot, push, pop, has_wr, rd_elig, cpu_elig, force_cpu;
   logic [21:0] head;
   // Slots are masked during reset so the combinational issue outputs also read as idle.
   assign slot = ce_vdp & reset_n;
   assign cpu_wr_ready = level_q != 5'(FIFO_DEPTH);
   assign push = cpu_wr_req & cpu_wr_ready;
   assign has_wr = level_q != 5'd0;
   assign rd_elig = rd_pend_q & ~has_wr;
   assign cpu_elig = has_wr | rd_elig;
   assign force_cpu = (starve_q == LIM) & cpu_elig;
   assign head = fifo_q[rd_ptr_q];
   assign fifo_level = level_q;
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         starve_q       <= '0;
         rd_pend_q      <= 1'b0;
         rd_addr_q      <= '0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         ren_data_q     <= '0;
         ren_valid_q    <= 1'b0;
         cpu_rd_data_q  <= '0;
         cpu_rd_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         starve_q       <= starve_d;
         rd_pend_q      <= rd_pend_d;
         rd_addr_q      <= rd_addr_d;
         mem_addr_q     <= mem_addr;
         mem_wdata_q    <= mem_wdata;
         ren_data_q     <= ren_data_d;
         ren_valid_q    <= ren_valid_d;
         cpu_rd_data_q  <= cpu_rd_data_d;
         cpu_rd_valid_q <= cpu_rd_valid_d;
      end
   end
   always_ff @(posedge clk_sys) begin
      if (push) fifo_q[wr_ptr_q] <= {cpu_wr_addr, cpu_wr_data};
   end
   always_comb begin
      state_d = !slot ? IDLE :
                force_cpu ? (has_wr ? CPU_WR : CPU_RD) :
                ren_req ? REN :
                has_wr ? CPU_WR :
                rd_elig ? CPU_RD : IDLE;
      starve_d = !slot ? starve_q :
                 (!cpu_elig || state_d == CPU_WR || state_d == CPU_RD) ? '0 :
                 (state_d == REN && starve_q != LIM) ? starve_q + SW'(1) : starve_q;
   end
   always_comb begin
      pop = state_d == CPU_WR;
      level_d = level_q + 5'(push) - 5'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      // A request landing in the issue cycle becomes a fresh pending read.
      rd_pend_d = cpu_rd_req | (rd_pend_q & (state_d != CPU_RD));
      rd_addr_d = cpu_rd_req ? cpu_rd_addr : rd_addr_q;
      ren_ack = state_d == REN;
      mem_we = pop;
      mem_addr = (state_d == REN) ? ren_addr :
                 (state_d == CPU_WR) ? head[21:8] :
                 (state_d == CPU_RD) ? rd_addr_q : mem_addr_q;
      mem_wdata = pop ? head[7:0] : mem_wdata_q;
      ren_valid_d = state_q == REN;
      ren_data_d = ren_valid_d ? mem_rdata : ren_data_q;
      cpu_rd_valid_d = state_q == CPU_RD;
      cpu_rd_data_d = cpu_rd_valid_d ? mem_rdata : cpu_rd_data_q;
      cpu_rd_busy = rd_pend_q | (state_q == CPU_RD);
      ren_data = ren_data_q;
      ren_valid = ren_valid_q;
      cpu_rd_data = cpu_rd_data_q;
      cpu_rd_valid = cpu_rd_valid_q;
   end
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb_vdp_vram_arbiter: directed scenarios against a synchronous VRAM model,
// with a negedge monitor logging every write, grant and return pulse.
module tb_vdp_vram_arbiter;
   logic        clk_sys = 1'b0, reset_n = 1'b0, ce_vdp = 1'b0, ren_req = 1'b0;
   logic        cpu_wr_req = 1'b0, cpu_rd_req = 1'b0;
   logic [13:0] ren_addr = '0, cpu_wr_addr = '0, cpu_rd_addr = '0;
   logic [7:0]  cpu_wr_data = '0;
   logic        ren_ack, ren_valid, cpu_wr_ready, cpu_rd_busy, cpu_rd_valid, mem_we;
   logic [7:0]  ren_data, cpu_rd_data, mem_wdata, mem_rdata;
   logic [13:0] mem_addr;
   logic [4:0]  fifo_level;
   logic [7:0]  vram [16384];
   int checks = 0, passes = 0;
   int rdv_cnt = 0, renv_cnt = 0, clash = 0;
   logic [7:0] rd_last = '0, ren_last = '0;
   logic [21:0] we_q [$];
   int gl [$];

   vdp_vram_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_vdp(ce_vdp),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_ack(ren_ack),
      .ren_data(ren_data), .ren_valid(ren_valid),
      .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_wr_ready(cpu_wr_ready), .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
      .cpu_rd_busy(cpu_rd_busy), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .fifo_level(fifo_level)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   // Grant log codes: 1 = render ack, 2 = CPU write, 0 = anything else.
   always @(negedge clk_sys) begin
      if (mem_we) we_q.push_back({mem_addr, mem_wdata});
      if (ce_vdp) gl.push_back(ren_ack ? 1 : mem_we ? 2 : 0);
      if (ren_ack && mem_we) clash++;
      if (cpu_rd_valid) begin rdv_cnt++; rd_last = cpu_rd_data; end
      if (ren_valid) begin renv_cnt++; ren_last = ren_data; end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [13:0] a, input logic [7:0] d);
      cpu_wr_req = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
      tick(1);
      cpu_wr_req = 1'b0;
   endtask

   task automatic slots(input int n);
      ce_vdp = 1'b1;
      tick(n);
      ce_vdp = 1'b0;
   endtask

   initial begin
      int wb, rb, gb, vb, n;
      tick(2);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ready", cpu_wr_ready, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_busy", cpu_rd_busy, 0);
      chk("rst_rd_data", cpu_rd_data, 0);
      reset_n = 1'b1;
      tick(2);
      // two writes then a read of the second address
      wb = we_q.size(); rb = rdv_cnt;
      push(14'h1234, 8'hAA);
      push(14'h1235, 8'hBB);
      cpu_rd_req = 1'b1; cpu_rd_addr = 14'h1235;
      tick(1);
      cpu_rd_req = 1'b0;
      chk("p1_level", fifo_level, 2);
      chk("p1_busy", cpu_rd_busy, 1);
      slots(3);
      chk("p1_busy_inflight", cpu_rd_busy, 1);
      tick(1);
      chk("p1_valid_pulse", cpu_rd_valid, 1);
      tick(2);
      chk("p1_we_count", we_q.size() - wb, 2);
      chk("p1_we0", we_q[wb], {14'h1234, 8'hAA});
      chk("p1_we1", we_q[wb+1], {14'h1235, 8'hBB});
      chk("p1_rdv", rdv_cnt - rb, 1);
      chk("p1_rd_data", rd_last, 8'hBB);
      chk("p1_busy_done", cpu_rd_busy, 0);
      // fill the queue with no slots, fifth push dropped
      wb = we_q.size();
      for (int i = 0; i < 4; i++) push(14'h2000 + 14'(i), 8'h10 + 8'(i));
      chk("p2_full_level", fifo_level, 4);
      chk("p2_not_ready", cpu_wr_ready, 0);
      push(14'h2004, 8'h99);
      chk("p2_drop_level", fifo_level, 4);
      slots(4);
      tick(2);
      chk("p2_level_empty", fifo_level, 0);
      chk("p2_ready", cpu_wr_ready, 1);
      chk("p2_we_count", we_q.size() - wb, 4);
      chk("p2_we_first", we_q[wb], {14'h2000, 8'h10});
      chk("p2_we_last", we_q[wb+3], {14'h2003, 8'h13});
      // continuous render traffic against one queued write
      push(14'h3000, 8'h77);
      ren_addr = 14'h3000; ren_req = 1'b1;
      gb = gl.size(); vb = renv_cnt;
      slots(12);
      ren_req = 1'b0;
      tick(3);
      n = 0;
      for (int i = 0; i < 8; i++) n += (gl[gb+i] == 1) ? 1 : 0;
      chk("p3_first8_render", n, 8);
      chk("p3_slot9_write", gl[gb+8], 2);
      chk("p3_slot10_render", gl[gb+9], 1);
      chk("p3_no_clash", clash, 0);
      chk("p3_ren_valids", renv_cnt - vb, 11);
      chk("p3_ren_data", ren_last, 8'h77);
      // latest read request before any slot wins
      push(14'h0100, 8'h11);
      push(14'h0200, 8'h22);
      slots(2);
      tick(2);
      rb = rdv_cnt;
      cpu_rd_req = 1'b1; cpu_rd_addr = 14'h0100;
      tick(1);
      cpu_rd_addr = 14'h0200;
      tick(1);
      cpu_rd_req = 1'b0;
      chk("p4_busy", cpu_rd_busy, 1);
      slots(1);
      tick(3);
      chk("p4_rdv", rdv_cnt - rb, 1);
      chk("p4_rd_data", rd_last, 8'h22);
      chk("p4_busy_done", cpu_rd_busy, 0);
      chk("p4_addr_held", mem_addr, 14'h0200);
      chk("p4_data_held", cpu_rd_data, 8'h22);
      // same-cycle write and read to one address
      wb = we_q.size(); rb = rdv_cnt;
      cpu_wr_req = 1'b1; cpu_wr_addr = 14'h0300; cpu_wr_data = 8'h5A;
      cpu_rd_req = 1'b1; cpu_rd_addr = 14'h0300;
      tick(1);
      cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
      slots(3);
      tick(3);
      chk("p5_we", we_q[wb], {14'h0300, 8'h5A});
      chk("p5_rdv", rdv_cnt - rb, 1);
      chk("p5_rd_data", rd_last, 8'h5A);
      // reset with queued writes and a pending read
      for (int i = 0; i < 3; i++) push(14'h0400 + 14'(i), 8'hC0 + 8'(i));
      cpu_rd_req = 1'b1; cpu_rd_addr = 14'h0400;
      tick(1);
      cpu_rd_req = 1'b0;
      chk("p6_level", fifo_level, 3);
      chk("p6_busy", cpu_rd_busy, 1);
      wb = we_q.size(); rb = rdv_cnt;
      ren_req = 1'b1; ce_vdp = 1'b1; reset_n = 1'b0;
      #1;
      chk("p6_rst_we", mem_we, 0);
      chk("p6_rst_ack", ren_ack, 0);
      chk("p6_rst_level", fifo_level, 0);
      chk("p6_rst_ready", cpu_wr_ready, 1);
      chk("p6_rst_busy", cpu_rd_busy, 0);
      chk("p6_rst_rd_data", cpu_rd_data, 0);
      chk("p6_rst_addr", mem_addr, 0);
      ren_req = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(8);
      ce_vdp = 1'b0;
      tick(2);
      chk("p6_no_we", we_q.size() - wb, 0);
      chk("p6_no_rdv", rdv_cnt - rb, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
